gan_param_loader: RTL and testbench
===================================

Name: gan_param_loader

Overview:
- Upstream configuration stage for the 8-layer pipelined GAN datapath.
- Receives a serial stream of 6-bit signed weights and biases over a valid/ready handshake and collects them in a shadow bank.
- Commits the shadow bank atomically to an active bank. The active bank drives every w_l*/b_l* input of the network through one flattened bus.
- In-flight pipeline computations never see a half-written parameter set.

Parameters:
- DATA_W, 6, width of one weight/bias word (signed two's complement).
- N_PARAMS, 73, words per frame: L1 20, L2 10, L3 3, L4 2, L5 2, L6 4, L7 12, L8 20.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  global gate. When low, FSM, counters and banks hold and cfg_ready=0.
- cfg_valid  in  1  word on cfg_data is valid.
- cfg_ready  out  1  loader can accept a word this cycle.
- cfg_data  in  DATA_W  parameter word.
- cfg_start  in  1  qualifies the first word of a frame (index 0).
- cfg_last  in  1  qualifies the final word of a frame (index N_PARAMS-1).
- param_bus  out  N_PARAMS*DATA_W  active bank; word k at bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- param_valid  out  1  high once at least one frame has committed since reset.
- commit_pulse  out  1  one-cycle pulse in the first cycle the new param_bus is visible.
- load_busy  out  1  state != IDLE.
- cfg_error  out  1  sticky framing error; cleared by the next accepted cfg_start word or by reset.

Behaviour:
- Word order per layer: weights in row-major index order (w_lL_11, _12, ..., _1n, _21, ...), then biases b_lL_1..n. Layers run L1..L8.
- Layer base indices: L1 0, L2 20, L3 30, L4 33, L5 35, L6 37, L7 41, L8 53.
- Reset: state=IDLE, idx=0, both banks all-zero, param_bus=0, param_valid=0, commit_pulse=0, cfg_error=0, load_busy=0.
- Handshake:
  - A word is accepted on a rising edge with cfg_valid & cfg_ready & enable.
  - cfg_ready = enable & (state != COMMIT).
  - cfg_data, cfg_start and cfg_last are sampled only on acceptance.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - Accepted word with cfg_start=1, cfg_last=0: write shadow[0], idx<=1, clear cfg_error, go to LOAD.
  - Accepted word with cfg_start=1, cfg_last=1: cfg_error<=1, stay in IDLE.
  - Accepted word with cfg_start=0: discarded, no flag change.
- LOAD, on accepted word:
  - cfg_start=1: restart. Write shadow[0], idx<=1, clear cfg_error.
  - idx<N_PARAMS-1 and cfg_last=1: early last. cfg_error<=1, go to IDLE, shadow contents are don't-care.
  - idx==N_PARAMS-1 and cfg_last=0: missing last. cfg_error<=1, go to IDLE.
  - idx==N_PARAMS-1 and cfg_last=1: write shadow[72], go to COMMIT.
  - Otherwise: write shadow[idx], idx<=idx+1.
- COMMIT (one enabled cycle): active<=shadow, param_valid<=1, commit_pulse<=1 for one cycle, idx<=0, go to IDLE.
- Latency: last word accepted at edge N → COMMIT during cycle N+1 → param_bus new value and commit_pulse=1 during cycle N+2.
- Minimum frame period: 74 cycles (73 words plus 1 COMMIT cycle). A cfg_start word is accepted in the cycle after COMMIT.
- enable low in any state freezes everything, including COMMIT, which completes on the next enabled cycle. commit_pulse deasserts after one enabled cycle.
- A failed frame never modifies the active bank. param_bus keeps the last committed set.
- Reset mid-load or in COMMIT: full reset values; the active bank is also zeroed.
- Data is stored verbatim; no arithmetic or sign extension inside the block.

Decomposition:
- Shared package/header gan_param_pkg holds:
  - DATA_W, N_PARAMS.
  - Layer base-index constants L1_BASE..L8_BASE.
  - FSM state encoding.
  - A per-layer count table.
- Sub-module gan_param_bank: double-buffered register bank with shadow write port (we, addr, data), a commit input, and the flattened active output.
- The FSM, index counter and error logic stay in gan_param_loader.

Test Plan:
- Clean frame: words k=0..72 with data = k mod 32 (word 0 cfg_start, word 72 cfg_last), no stalls → commit_pulse at 2 cycles after word 72; param_bus word 20 = 6'd20, word 53 = 6'd21; param_valid=1.
- Early cfg_last at idx 40 after a committed frame → cfg_error=1, state IDLE, param_bus unchanged. A following clean frame of all 6'h3F (-1) clears cfg_error and commits every word = 6'h3F.
- Random cfg_valid gaps plus enable low for 5 cycles in the COMMIT cycle → commit_pulse is delayed exactly 5 cycles, is one cycle wide, and data matches.
- cfg_start re-asserted at idx 30 with data 6'h05 → restart; a completed frame has word 0 = 6'h05 and the old partial data is not visible.
- reset pulsed while idx=50 → next cycle param_bus=0, param_valid=0, load_busy=0. Words without cfg_start are then ignored.
- Back-to-back frames A then B at the 74-cycle minimum period → two commit_pulses 74 cycles apart; param_bus equals A, then B.

Source files
------------

// File: rtl/gan_param_pkg.sv
// Shared constants, layer map and FSM encoding for the GAN parameter loader.
package gan_param_pkg;

  localparam int DATA_W   = 6;
  localparam int N_PARAMS = 73;
  localparam int IDX_W    = 7;
  localparam int BUS_W    = N_PARAMS * DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = 7'd72;

  localparam int L1_BASE = 0;
  localparam int L2_BASE = 20;
  localparam int L3_BASE = 30;
  localparam int L4_BASE = 33;
  localparam int L5_BASE = 35;
  localparam int L6_BASE = 37;
  localparam int L7_BASE = 41;
  localparam int L8_BASE = 53;

  localparam int N_LAYERS = 8;
  localparam int LAYER_CNT [N_LAYERS] = '{20, 10, 3, 2, 2, 4, 12, 20};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Base word index of a layer (0-based layer number), derived from the count table.
  function automatic int layer_base(input int layer);
    int sum;
    sum = 0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (i < layer) begin
        sum = sum + LAYER_CNT[i];
      end else begin
        sum = sum + 0;
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/gan_param_bank.sv
// Double-buffered parameter store: shadow write port, atomic copy to the active bank.
module gan_param_bank
  import gan_param_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] data,
  input  logic              commit,
  output logic [BUS_W-1:0]  active
);

  logic [DATA_W-1:0] shadow_r [N_PARAMS];
  logic [DATA_W-1:0] active_r [N_PARAMS];

  // Shadow writes and whole-bank commit; the loader never asserts both together.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_PARAMS; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_PARAMS; k++) begin
        if (we && (addr == IDX_W'(k))) begin
          shadow_r[k] <= data;
        end
        if (commit) begin
          active_r[k] <= shadow_r[k];
        end
      end
    end
  end

  // Flatten the active bank; word k occupies bits [DATA_W*k +: DATA_W].
  always_comb begin
    active = '0;
    for (int k = 0; k < N_PARAMS; k++) begin
      active[k*DATA_W +: DATA_W] = active_r[k];
    end
  end

endmodule

// File: rtl/gan_param_loader.sv
// Framed serial loader for the GAN weights/biases; commits whole frames atomically.
module gan_param_loader
  import gan_param_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_start,
  input  logic              cfg_last,
  output logic [BUS_W-1:0]  param_bus,
  output logic              param_valid,
  output logic              commit_pulse,
  output logic              load_busy,
  output logic              cfg_error
);

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               cfg_error_r;
  logic               param_valid_r;
  logic               commit_pulse_r;
  logic               ready_s;
  logic               accept_s;
  logic               we_s;
  logic [IDX_W-1:0]   waddr_s;
  logic               commit_s;

  // Handshake qualification and shadow write decode.
  always_comb begin
    ready_s  = enable & (state_r != ST_COMMIT);
    accept_s = enable & cfg_valid & ready_s;
    commit_s = enable & (state_r == ST_COMMIT);
    we_s     = 1'b0;
    waddr_s  = '0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_start && !cfg_last) begin
            we_s = 1'b1;
          end else begin
            we_s = 1'b0;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            we_s = 1'b1;
          end else if ((idx_r == LAST_IDX) == cfg_last) begin
            // Only an in-order word whose cfg_last matches its position is stored.
            we_s    = 1'b1;
            waddr_s = idx_r;
          end else begin
            we_s = 1'b0;
          end
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end else begin
      we_s = 1'b0;
    end
  end

  // Framing FSM, word index and status flags; everything holds while enable is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      idx_r          <= '0;
      cfg_error_r    <= 1'b0;
      param_valid_r  <= 1'b0;
      commit_pulse_r <= 1'b0;
    end else if (enable) begin
      commit_pulse_r <= (state_r == ST_COMMIT);
      case (state_r)
        ST_IDLE: begin
          if (accept_s && cfg_start) begin
            if (cfg_last) begin
              cfg_error_r <= 1'b1;
            end else begin
              idx_r       <= IDX_W'(1);
              cfg_error_r <= 1'b0;
              state_r     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (cfg_start) begin
              idx_r       <= IDX_W'(1);
              cfg_error_r <= 1'b0;
            end else if (idx_r == LAST_IDX) begin
              if (cfg_last) begin
                state_r <= ST_COMMIT;
              end else begin
                cfg_error_r <= 1'b1;
                idx_r       <= '0;
                state_r     <= ST_IDLE;
              end
            end else if (cfg_last) begin
              cfg_error_r <= 1'b1;
              idx_r       <= '0;
              state_r     <= ST_IDLE;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          param_valid_r <= 1'b1;
          idx_r         <= '0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  gan_param_bank u_bank (
    .clock  (clock),
    .reset  (reset),
    .we     (we_s),
    .addr   (waddr_s),
    .data   (cfg_data),
    .commit (commit_s),
    .active (param_bus)
  );

  assign cfg_ready    = ready_s;
  assign param_valid  = param_valid_r;
  assign commit_pulse = commit_pulse_r;
  assign cfg_error    = cfg_error_r;
  assign load_busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_gan_param_loader.sv
// Randomized self-checking bench for gan_param_loader with a queue-based frame model.
module tb_gan_param_loader;
  import gan_param_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DATA_W-1:0] cfg_data = '0;
  logic              cfg_start = 1'b0;
  logic              cfg_last = 1'b0;
  logic [BUS_W-1:0]  param_bus;
  logic              param_valid;
  logic              commit_pulse;
  logic              load_busy;
  logic              cfg_error;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state: words collected so far, and the committed set.
  logic [DATA_W-1:0] m_q [$];
  logic [DATA_W-1:0] m_active [N_PARAMS];
  bit                m_in_frame;
  bit                m_error;
  bit                m_valid;

  logic [DATA_W-1:0] frame_d [N_PARAMS];
  int                pulse_cyc [$];
  logic [BUS_W-1:0]  pulse_bus [$];

  gan_param_loader dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_start(cfg_start),
    .cfg_last(cfg_last), .param_bus(param_bus), .param_valid(param_valid),
    .commit_pulse(commit_pulse), .load_busy(load_busy), .cfg_error(cfg_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    if (commit_pulse === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_bus.push_back(param_bus);
    end
  end

  task automatic model_reset();
    m_q.delete();
    m_in_frame = 0;
    m_error = 0;
    m_valid = 0;
    for (int k = 0; k < N_PARAMS; k++) m_active[k] = '0;
  endtask

  // Frame rules applied to one accepted word.
  task automatic model_word(input logic [DATA_W-1:0] d, input logic s, input logic l);
    if (s) begin
      if (!m_in_frame && l) begin
        m_error = 1;
      end else begin
        m_q.delete();
        m_q.push_back(d);
        m_in_frame = 1;
        m_error = 0;
      end
    end else if (m_in_frame) begin
      if (m_q.size() == N_PARAMS - 1) begin
        if (l) begin
          m_q.push_back(d);
          for (int k = 0; k < N_PARAMS; k++) m_active[k] = m_q[k];
          m_valid = 1;
        end else begin
          m_error = 1;
        end
        m_in_frame = 0;
      end else if (l) begin
        m_error = 1;
        m_in_frame = 0;
      end else begin
        m_q.push_back(d);
      end
    end
  endtask

  function automatic logic [BUS_W-1:0] model_bus();
    logic [BUS_W-1:0] b;
    b = '0;
    for (int k = 0; k < N_PARAMS; k++) b[k*DATA_W +: DATA_W] = m_active[k];
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic s, input logic l);
    bit done;
    done = 0;
    cfg_data = d;
    cfg_start = s;
    cfg_last = l;
    cfg_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      if (cfg_ready === 1'b1 && enable === 1'b1) done = 1;
      step(1);
    end
    cfg_valid = 1'b0;
    if (done) begin
      model_word(d, s, l);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL send_word_timeout: word not accepted, cfg_ready=%b required 1", cfg_ready);
    end
  endtask

  // Sends frame_d[first..upto]; word 0 carries cfg_start, word N_PARAMS-1 carries cfg_last.
  task automatic send_range(input int first, input int upto, input bit gaps);
    for (int k = first; k <= upto; k++) begin
      if (gaps) step($urandom_range(0, 2));
      send_word(frame_d[k], k == 0, k == N_PARAMS - 1);
    end
  endtask

  task automatic wait_pulse(output int edges);
    edges = -1;
    for (int i = 1; i <= 20 && edges < 0; i++) begin
      step(1);
      if (commit_pulse === 1'b1) edges = i;
    end
    if (edges < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL commit_timeout: commit_pulse never rose within 20 cycles");
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < N_PARAMS; k++) frame_d[k] = DATA_W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL reset_bus: got %h required %h", param_bus, model_bus()); end
    n_checks++;
    if ({param_valid, commit_pulse, load_busy, cfg_error} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {param_valid, commit_pulse, load_busy, cfg_error});
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
  endtask

  task automatic test_clean_frame();
    int e;
    for (int k = 0; k < N_PARAMS; k++) frame_d[k] = DATA_W'(k % 32);
    send_range(0, N_PARAMS - 1, 0);
    n_checks++;
    if ({commit_pulse, load_busy, cfg_ready} !== 3'b010) begin
      n_fail++; $display("FAIL clean_commit_state: pulse/busy/ready got %b required 010", {commit_pulse, load_busy, cfg_ready});
    end
    wait_pulse(e);
    n_checks++;
    if (e !== 1) begin n_fail++; $display("FAIL clean_latency: pulse after %0d edges required 1", e); end
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL clean_bus: got %h required %h", param_bus, model_bus()); end
    n_checks++;
    if (param_bus[L2_BASE*DATA_W +: DATA_W] !== 6'd20) begin n_fail++; $display("FAIL clean_w20: got %h required 14", param_bus[L2_BASE*DATA_W +: DATA_W]); end
    n_checks++;
    if (param_bus[layer_base(7)*DATA_W +: DATA_W] !== 6'd21) begin n_fail++; $display("FAIL clean_w53: got %h required 15", param_bus[L8_BASE*DATA_W +: DATA_W]); end
    n_checks++;
    if (param_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid: got %b required 1", param_valid); end
    step(1);
    n_checks++;
    if ({commit_pulse, load_busy} !== 2'b00) begin n_fail++; $display("FAIL clean_pulse_width: pulse/busy got %b required 00", {commit_pulse, load_busy}); end
  endtask

  task automatic test_early_last();
    int e;
    logic [BUS_W-1:0] ones;
    fill_random();
    for (int k = 0; k <= 40; k++) send_word(frame_d[k], k == 0, k == 40);
    step(2);
    n_checks++;
    if ({cfg_error, load_busy} !== {m_error, 1'b0}) begin n_fail++; $display("FAIL early_flags: err/busy got %b required %b0", {cfg_error, load_busy}, m_error); end
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL early_bus_kept: got %h required %h", param_bus, model_bus()); end
    for (int k = 0; k < N_PARAMS; k++) frame_d[k] = 6'h3F;
    send_range(0, 0, 0);
    n_checks++;
    if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL early_err_clear: got %b required 0", cfg_error); end
    send_range(1, N_PARAMS - 1, 0);
    wait_pulse(e);
    ones = '1;
    n_checks++;
    if (param_bus !== ones || param_bus !== model_bus()) begin n_fail++; $display("FAIL ones_bus: got %h required %h", param_bus, ones); end
  endtask

  task automatic test_enable_stall();
    int e;
    fill_random();
    send_range(0, N_PARAMS - 1, 1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++;
      if ({commit_pulse, load_busy, cfg_ready} !== 3'b010) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d pulse/busy/ready got %b required 010", i, {commit_pulse, load_busy, cfg_ready});
      end
    end
    enable = 1'b1;
    wait_pulse(e);
    n_checks++;
    if (e !== 1) begin n_fail++; $display("FAIL stall_latency: pulse %0d edges after re-enable required 1", e); end
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL stall_bus: got %h required %h", param_bus, model_bus()); end
    step(1);
    n_checks++;
    if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL stall_pulse_width: got %b required 0", commit_pulse); end
  endtask

  task automatic test_restart();
    int e;
    fill_random();
    send_range(0, 29, 0);
    fill_random();
    frame_d[0] = 6'h05;
    send_range(0, N_PARAMS - 1, 0);
    wait_pulse(e);
    n_checks++;
    if (param_bus[DATA_W-1:0] !== 6'h05) begin n_fail++; $display("FAIL restart_w0: got %h required 05", param_bus[DATA_W-1:0]); end
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL restart_bus: got %h required %h", param_bus, model_bus()); end
  endtask

  task automatic test_reset_midload();
    fill_random();
    send_range(0, 49, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL midreset_bus: got %h required 0", param_bus); end
    n_checks++;
    if ({param_valid, load_busy, cfg_error} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b required 000", {param_valid, load_busy, cfg_error}); end
    for (int k = 50; k < N_PARAMS; k++) send_word(frame_d[k], 1'b0, k == N_PARAMS - 1);
    step(2);
    n_checks++;
    if ({param_valid, load_busy, commit_pulse} !== {m_valid, 2'b00}) begin
      n_fail++; $display("FAIL midreset_ignore: valid/busy/pulse got %b required 000", {param_valid, load_busy, commit_pulse});
    end
    n_checks++;
    if (param_bus !== model_bus()) begin n_fail++; $display("FAIL midreset_ignore_bus: got %h required 0", param_bus); end
  endtask

  task automatic test_back_to_back();
    logic [BUS_W-1:0] exp_a;
    logic [BUS_W-1:0] exp_b;
    pulse_cyc.delete();
    pulse_bus.delete();
    fill_random();
    send_range(0, N_PARAMS - 1, 0);
    exp_a = model_bus();
    fill_random();
    send_range(0, N_PARAMS - 1, 0);
    exp_b = model_bus();
    step(3);
    n_checks++;
    if (pulse_cyc.size() !== 2) begin
      n_fail++; $display("FAIL b2b_pulse_count: got %0d required 2", pulse_cyc.size());
    end else begin
      n_checks++;
      if (pulse_cyc[1] - pulse_cyc[0] !== 74) begin n_fail++; $display("FAIL b2b_period: got %0d required 74", pulse_cyc[1] - pulse_cyc[0]); end
      n_checks++;
      if (pulse_bus[0] !== exp_a) begin n_fail++; $display("FAIL b2b_bus_a: got %h required %h", pulse_bus[0], exp_a); end
      n_checks++;
      if (pulse_bus[1] !== exp_b) begin n_fail++; $display("FAIL b2b_bus_b: got %h required %h", pulse_bus[1], exp_b); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_early_last();
    test_enable_stall();
    test_restart();
    test_reset_midload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
